// File: rtl/lcd_feeder_pkg.sv
// lcd_feeder_pkg: shared state encoding for the transmitter feeder
package lcd_feeder_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;
endpackage

// File: rtl/lcd_fifo.sv
// lcd_fifo: synchronous circular FIFO with exact occupancy count
module lcd_fifo #(
  parameter int W = 32,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [DEPTH_LOG:0]   level,
  output logic                 full,
  output logic                 empty
);
  localparam int D = 2 ** DEPTH_LOG;
  logic [W-1:0] mem [D];
  logic [DEPTH_LOG-1:0] wptr, rptr;
  logic wr, rd;
  assign empty = level == '0;
  assign full = level == (DEPTH_LOG+1)'(D);
  assign rd = pop && !empty;
  // a pop on the same edge frees a slot, so a full FIFO still accepts
  assign wr = push && (!full || rd);
  assign dout = mem[rptr];
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      wptr <= wptr + DEPTH_LOG'(wr);
      rptr <= rptr + DEPTH_LOG'(rd);
      level <= level + (DEPTH_LOG+1)'(wr) - (DEPTH_LOG+1)'(rd);
    end
  end
endmodule

// File: rtl/lcd_feeder.sv
// lcd_feeder: buffers bursty words and drains them one at a time into the serial transmitter
module lcd_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int DIGIT = 8,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIGIT*4-1:0]   DIN,
  input  logic                 DIN_WE,
  output logic                 FULL,
  output logic [DEPTH_LOG:0]   LEVEL,
  output logic                 OVF,
  output logic [DIGIT*4-1:0]   DOUT,
  output logic                 DOUT_WE,
  input  logic                 LCD_READY
);
  state_t state, state_nx;
  logic [DIGIT*4-1:0] head;
  logic empty, pop;
  lcd_fifo #(.W(DIGIT*4), .DEPTH_LOG(DEPTH_LOG)) u_fifo (
    .clk(CLK), .rst(RST), .push(DIN_WE), .pop(pop), .din(DIN),
    .dout(head), .level(LEVEL), .full(FULL), .empty(empty)
  );
  // GUARD skips one cycle so the transmitter's registered READY fall is never misread
  always_comb begin
    pop = state == IDLE && !empty && LCD_READY;
    state_nx = state == IDLE  ? (pop ? ISSUE : IDLE) :
               state == ISSUE ? GUARD :
               state == GUARD ? WAIT :
               (LCD_READY ? IDLE : WAIT);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      DOUT <= '0;
      DOUT_WE <= 1'b0;
      OVF <= 1'b0;
    end else begin
      state <= state_nx;
      DOUT_WE <= pop;
      if (pop) DOUT <= head;
      if (DIN_WE && FULL && !pop) OVF <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lcd_feeder.sv
// tb_lcd_feeder: directed and soak checks of the feeder against a queue model and a READY-latency transmitter model
module tb_lcd_feeder;
  localparam int D = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] DIN = '0;
  logic DIN_WE = 1'b0;
  logic FULL, OVF, DOUT_WE;
  logic [2:0] LEVEL;
  logic [31:0] DOUT;
  logic LCD_READY = 1'b1;

  lcd_feeder #(.DIGIT(8), .DEPTH_LOG(2)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_WE(DIN_WE), .FULL(FULL), .LEVEL(LEVEL),
    .OVF(OVF), .DOUT(DOUT), .DOUT_WE(DOUT_WE), .LCD_READY(LCD_READY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] push_q [$];
  logic [31:0] got_q [$];
  logic [31:0] last_dout;
  int mlevel, drops, busy, since;
  bit ready, hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    DIN_WE = 1'b0;
    LCD_READY = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_level", LEVEL, 0);
    chk("rst_full", FULL, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_dout_we", DOUT_WE, 0);
    exp_q.delete();
    push_q.delete();
    got_q.delete();
    last_dout = '0;
    mlevel = 0;
    drops = 0;
    busy = 0;
    since = 99;
    ready = 1'b1;
    hold = 1'b0;
  endtask

  // lat < 0 picks a random READY-low time per word
  task automatic run(input int n, input int lat, input int push_pct);
    for (int c = 0; c < n; c++) begin
      bit pushing, popped, rdy_edge, accepted;
      logic [31:0] w;
      pushing = 1'b0;
      w = '0;
      if (push_q.size() > 0) begin
        pushing = 1'b1;
        w = push_q.pop_front();
      end else if (push_pct > 0 && $urandom_range(99) < push_pct) begin
        pushing = 1'b1;
        w = $urandom;
      end
      rdy_edge = hold ? 1'b0 : ready;
      DIN = w;
      DIN_WE = pushing;
      LCD_READY = rdy_edge;
      tick();
      popped = DOUT_WE;
      since++;
      if (popped) begin
        chk("pop_ready", 32'(rdy_edge), 1);
        chk("pop_spacing", 32'(since >= 4), 1);
        since = 0;
        chk("pop_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("pop_data", DOUT, exp_q.pop_front());
        got_q.push_back(DOUT);
        last_dout = DOUT;
      end else begin
        chk("dout_hold", DOUT, last_dout);
      end
      accepted = pushing && (mlevel < D || popped);
      if (accepted) exp_q.push_back(w);
      else if (pushing) drops++;
      mlevel = mlevel + int'(accepted) - int'(popped);
      chk("level", LEVEL, mlevel);
      chk("full", FULL, 32'(mlevel == D));
      chk("ovf", OVF, 32'(drops > 0));
      if (popped) busy = lat < 0 ? int'($urandom_range(6)) : lat;
      else if (busy > 0) busy--;
      ready = busy == 0;
    end
    DIN_WE = 1'b0;
  endtask

  initial begin
    logic [31:0] burst_exp [5];
    logic [31:0] ovf_exp [4];
    burst_exp = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
    ovf_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_reset();

    // single word: DIN_WE cycle c, DOUT_WE cycle c+2, one cycle wide
    DIN = 32'h1234abcd;
    DIN_WE = 1'b1;
    tick();
    DIN_WE = 1'b0;
    chk("single_level1", LEVEL, 1);
    chk("single_we_early", DOUT_WE, 0);
    tick();
    chk("single_we", DOUT_WE, 1);
    chk("single_dout", DOUT, 32'h1234abcd);
    chk("single_level0", LEVEL, 0);
    tick();
    chk("single_we_drop", DOUT_WE, 0);
    tick();
    tick();
    chk("single_hold", DOUT, 32'h1234abcd);
    chk("single_we_quiet", DOUT_WE, 0);

    // burst under a slow consumer
    do_reset();
    push_q = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
    run(600, 100, 0);
    chk("burst_count", got_q.size(), 5);
    if (got_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("burst_order", got_q[i], burst_exp[i]);

    // overflow with READY held low
    do_reset();
    hold = 1'b1;
    push_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run(4, 0, 0);
    chk("ovf_full4", FULL, 1);
    chk("ovf_level4", LEVEL, 4);
    chk("ovf_not_yet", OVF, 0);
    push_q = '{32'hA4, 32'hA5};
    run(2, 0, 0);
    chk("ovf_set", OVF, 1);
    chk("ovf_level", LEVEL, 4);
    hold = 1'b0;
    run(40, 1, 0);
    chk("ovf_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("ovf_order", got_q[i], ovf_exp[i]);
    chk("ovf_drained", LEVEL, 0);
    chk("ovf_sticky", OVF, 1);

    // full FIFO with push on the issue edge
    do_reset();
    hold = 1'b1;
    push_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    run(4, 0, 0);
    hold = 1'b0;
    push_q = '{32'hBB};
    run(1, 1, 0);
    chk("sim_issue", DOUT_WE, 1);
    chk("sim_level", LEVEL, 4);
    chk("sim_ovf", OVF, 0);
    run(40, 1, 0);
    chk("sim_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk("sim_first", got_q[0], 32'hC0);
      chk("sim_last", got_q[4], 32'hBB);
    end

    // reset while the transmitter is busy with words still queued
    do_reset();
    hold = 1'b1;
    push_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    run(4, 0, 0);
    hold = 1'b0;
    run(1, 50, 0);
    chk("mid_issue", DOUT_WE, 1);
    chk("mid_level", LEVEL, 3);
    do_reset();
    run(30, 0, 0);
    chk("mid_silent", got_q.size(), 0);

    // random soak then drain
    do_reset();
    run(10000, -1, 35);
    run(300, -1, 0);
    chk("soak_drained", exp_q.size(), 0);
    chk("soak_level", LEVEL, 0);
    chk("soak_ovf", OVF, 32'(drops > 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
